gamate_link_tx: RTL and testbench



---
 rtl/gamate_pkg.sv | 25 ++
 rtl/gamate_baud_gen.sv | 44 ++++
 rtl/gamate_link_tx.sv | 127 ++++++++++++
 tb/tb_gamate_link_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gamate_pkg.sv
// Shared definitions for the Gamate link port: state encodings, register map,
// control bit positions and the address window of the transmitter.
package gamate_pkg;

  typedef enum logic [2:0] {
    LTX_IDLE,
    LTX_START,
    LTX_DATA,
    LTX_PARITY,
    LTX_STOP
  } link_tx_state_t;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_DIV  = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_PAR_EN  = 1;
  localparam int CTRL_PAR_ODD = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam logic [15:0] LINK_TX_BASE = 16'h4C00;

endpackage

// File: rtl/gamate_baud_gen.sv
// Bit-time generator: a PRESCALE-tick prescaler feeding a baud counter that
// runs 0..div; bit_end pulses on the ce tick that closes the current bit.
module gamate_baud_gen #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       restart,
  input  logic [7:0] div,
  output logic       bit_end
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q;
  logic [7:0]    baud_q;
  logic [7:0]    div_q;
  logic          pre_wrap;

  assign pre_wrap = (pre_q == PW'(PRESCALE - 1));
  assign bit_end  = ce & pre_wrap & (baud_q == div_q);

  // div is captured only at a bit boundary so a mid-bit write shapes the next bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      baud_q <= '0;
      div_q  <= '0;
    end else if (ce) begin
      if (restart || bit_end) begin
        pre_q  <= '0;
        baud_q <= '0;
        div_q  <= div;
      end else if (pre_wrap) begin
        pre_q  <= '0;
        baud_q <= baud_q + 8'd1;
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/gamate_link_tx.sv
// Link port transmitter: one-entry holding register feeding an 8N1/8E1/8O1
// serialiser, with status/ctrl/divisor registers and a level IRQ.
module gamate_link_tx
  import gamate_pkg::*;
#(
  parameter int         PRESCALE  = 4,
  parameter logic [7:0] DIV_RESET = 8'd114
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ce,
  input  logic           cs,
  input  logic           rwn,
  input  logic [1:0]     addr,
  input  logic [7:0]     din,
  output logic [7:0]     dout,
  output logic           tx,
  output logic           busy,
  output logic           irq_n,
  output link_tx_state_t state_dbg
);

  link_tx_state_t state_q, state_d;
  logic [7:0] hold_q, shifter_q, div_q;
  logic [3:0] ctrl_q;
  logic [2:0] bit_cnt_q;
  logic       hold_empty_q, overrun_q, par_q;
  logic       bit_end, wr_en, wr_data, wr_stat, wr_ctrl, wr_div;
  logic       load_cond, frame_end, load, ovr_set;

  assign wr_en     = cs & ~rwn & ce;
  assign wr_data   = wr_en & (addr == REG_DATA);
  assign wr_stat   = wr_en & (addr == REG_STAT);
  assign wr_ctrl   = wr_en & (addr == REG_CTRL);
  assign wr_div    = wr_en & (addr == REG_DIV);
  assign load_cond = ctrl_q[CTRL_EN] & ~hold_empty_q;
  assign frame_end = (state_q == LTX_STOP) & bit_end;
  assign load      = ce & load_cond & ((state_q == LTX_IDLE) | frame_end);
  // A write that lands on a load edge refills the register the shifter just emptied.
  assign ovr_set   = wr_data & ~hold_empty_q & ~load;

  gamate_baud_gen #(.PRESCALE(PRESCALE)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .restart (state_q == LTX_IDLE),
    .div     (div_q),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= LTX_IDLE;
    else if (ce)  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LTX_IDLE:   if (load_cond) state_d = LTX_START;
      LTX_START:  if (bit_end) state_d = LTX_DATA;
      LTX_DATA:   if (bit_end && bit_cnt_q == 3'd7)
                    state_d = ctrl_q[CTRL_PAR_EN] ? LTX_PARITY : LTX_STOP;
      LTX_PARITY: if (bit_end) state_d = LTX_STOP;
      LTX_STOP:   if (bit_end) state_d = load_cond ? LTX_START : LTX_IDLE;
      default:    state_d = LTX_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      LTX_START:  tx = 1'b0;
      LTX_DATA:   tx = shifter_q[bit_cnt_q];
      LTX_PARITY: tx = par_q;
      default:    tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shifter_q <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
    end else if (load) begin
      shifter_q <= hold_q;
      bit_cnt_q <= '0;
    end else if (state_q == LTX_DATA && bit_end) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      // Parity sense is taken at the start of the parity bit.
      if (bit_cnt_q == 3'd7) par_q <= ^shifter_q ^ ctrl_q[CTRL_PAR_ODD];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q       <= '0;
      hold_empty_q <= 1'b1;
      overrun_q    <= 1'b0;
      ctrl_q       <= '0;
      div_q        <= DIV_RESET;
      irq_n        <= 1'b1;
    end else if (ce) begin
      irq_n <= ~(ctrl_q[CTRL_IRQ_EN] & hold_empty_q);
      if (wr_data && (hold_empty_q || load)) hold_q <= din;
      if (load && !wr_data)                  hold_empty_q <= 1'b1;
      else if (wr_data && hold_empty_q)      hold_empty_q <= 1'b0;
      if (ovr_set)                   overrun_q <= 1'b1;
      else if (wr_stat && din[0])    overrun_q <= 1'b0;
      if (wr_ctrl) ctrl_q <= din[3:0];
      if (wr_div)  div_q  <= din;
    end
  end

  always_comb begin
    dout = 8'h00;
    unique case (addr)
      REG_DATA: dout = hold_q;
      REG_STAT: dout = {5'b0, overrun_q, state_q != LTX_IDLE, hold_empty_q};
      REG_CTRL: dout = {4'b0, ctrl_q};
      default:  dout = div_q;
    endcase
  end

  assign busy      = (state_q != LTX_IDLE) | ~hold_empty_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gamate_link_tx.sv
// Bench for gamate_link_tx: table-driven frames, hand sequences for the timing
// corners, and a randomized phase checked against a bit-queue reference model.
module tb_gamate_link_tx;
  import gamate_pkg::*;

  localparam int P = 4;

  logic clk = 1'b0, reset_n = 1'b0, ce = 1'b1, cs = 1'b0, rwn = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout;
  logic tx, busy, irq_n;
  link_tx_state_t state_dbg;

  int errors = 0, checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  gamate_link_tx #(.PRESCALE(P), .DIV_RESET(8'd114)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cs(cs), .rwn(rwn), .addr(addr),
    .din(din), .dout(dout), .tx(tx), .busy(busy), .irq_n(irq_n), .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the line is a queue of pending bits; the front bit is on tx.
  // Code 2 stands for "parity if enabled", resolved when it reaches the front.
  logic [1:0] exp_q[$];
  int         m_rem = 0;
  logic [7:0] m_hold = 8'h00, m_frame = 8'h00, m_div = 8'd114;
  logic [3:0] m_ctrl = 4'h0;
  logic       m_empty = 1'b1, m_ovr = 1'b0, m_irq_n = 1'b1;

  always @(posedge clk or negedge reset_n) begin : model
    logic [7:0] od;
    logic [3:0] oc;
    logic oe, ld, wd;
    if (!reset_n) begin
      exp_q.delete();
      m_rem = 0; m_hold = 8'h00; m_div = 8'd114; m_ctrl = 4'h0;
      m_empty = 1'b1; m_ovr = 1'b0; m_irq_n = 1'b1;
    end else if (ce) begin
      od = m_div; oc = m_ctrl; oe = m_empty;
      if (exp_q.size() > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          void'(exp_q.pop_front());
          if (exp_q.size() > 0) begin
            if (exp_q[0] == 2'd2) begin
              if (oc[1]) exp_q[0] = {1'b0, ^m_frame ^ oc[2]};
              else void'(exp_q.pop_front());
            end
            m_rem = (int'(od) + 1) * P;
          end
        end
      end
      ld = (exp_q.size() == 0) && oc[0] && !oe;
      wd = cs && !rwn && addr == 2'd0;
      if (ld) begin
        m_frame = m_hold;
        exp_q.push_back(2'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, m_hold[i]});
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        m_rem = (int'(od) + 1) * P;
      end
      m_irq_n = !(oc[3] && oe);
      if (ld && wd) m_hold = din;
      else if (ld) m_empty = 1'b1;
      else if (wd) begin
        if (oe) begin m_hold = din; m_empty = 1'b0; end
        else m_ovr = 1'b1;
      end
      if (cs && !rwn && addr == 2'd1 && din[0] && !(wd && !oe && !ld)) m_ovr = 1'b0;
      if (cs && !rwn && addr == 2'd2) m_ctrl = din[3:0];
      if (cs && !rwn && addr == 2'd3) m_div = din;
    end
  end

  function automatic logic m_tx();
    return (exp_q.size() > 0) ? exp_q[0][0] : 1'b1;
  endfunction

  function automatic logic [7:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_hold;
      2'd1:    return {5'b0, m_ovr, exp_q.size() != 0, m_empty};
      2'd2:    return {4'b0, m_ctrl};
      default: return m_div;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      chk("mon_tx", tx, m_tx());
      chk("mon_busy", busy, (exp_q.size() != 0) || !m_empty);
      chk("mon_irq_n", irq_n, m_irq_n);
    end
  end

  // Driver tasks: entered at a negedge, return at the next negedge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    ce = 1'b1; cs = 1'b1; rwn = 1'b0; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; rwn = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input string name, input logic [7:0] exp);
    addr = a; rwn = 1'b1;
    #1 chk(name, dout, exp);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ce = ($urandom_range(0, 3) != 0); cs = 1'b0;
      @(negedge clk);
    end
    ce = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (busy === 1'b0 && tx === 1'b1) break;
      @(negedge clk);
    end
    if (i == limit) chk("idle_timeout", 0, 1);
  endtask

  // Samples mid-bit from cycle c0 of a frame whose start bit was seen at cycle 0.
  task automatic rx_frame(input int t, input int nb, input int c0, output logic [10:0] fr);
    fr = '0;
    for (int c = c0; c < nb * t; c++) begin
      if (c % t == t / 2) fr[c / t] = tx;
      @(negedge clk);
    end
  endtask

  typedef struct { logic [1:0] a; logic [7:0] exp; } rvec_t;
  typedef struct { logic [7:0] ctrl; logic [7:0] div; logic [7:0] data; int nb; logic par; } fvec_t;

  rvec_t rv[3];
  fvec_t fv[5];
  logic [10:0] fr;
  logic [9:0] pat;

  initial begin
    rv[0] = '{2'd1, 8'h01};
    rv[1] = '{2'd3, 8'd114};
    rv[2] = '{2'd2, 8'h00};
    fv[0] = '{8'h01, 8'd0, 8'h47, 10, 1'b0};
    fv[1] = '{8'h03, 8'd0, 8'h07, 11, 1'b1};
    fv[2] = '{8'h07, 8'd0, 8'h07, 11, 1'b0};
    fv[3] = '{8'h03, 8'd1, 8'hA5, 11, 1'b0};
    fv[4] = '{8'h07, 8'd2, 8'h3C, 11, 1'b1};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_irq_n", irq_n, 1);
    foreach (rv[i]) rd(rv[i].a, $sformatf("rst_reg%0d", rv[i].a), rv[i].exp);

    // 8N1 exact waveform plus status during/after the frame
    wr(2, 8'h01); wr(3, 8'h00); wr(0, 8'h47);
    chk("lat_pre", tx, 1);
    @(negedge clk);
    pat = 10'b1010001110;
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("w8n1_c%0d", c), tx, pat[c / 4]);
      if (c == 6) begin addr = 2'd1; #1 chk("stat_busy", dout, 8'h03); end
      @(negedge clk);
    end
    rd(1, "stat_after", 8'h01);

    foreach (fv[i]) begin
      wr(2, fv[i].ctrl); wr(3, fv[i].div); wr(0, fv[i].data);
      chk("fv_lat_pre", tx, 1);
      @(negedge clk);
      chk("fv_start", tx, 0);
      rx_frame((int'(fv[i].div) + 1) * P, fv[i].nb, 0, fr);
      chk($sformatf("fv%0d_data", i), fr[8:1], fv[i].data);
      if (fv[i].nb == 11) chk($sformatf("fv%0d_par", i), fr[9], fv[i].par);
      chk($sformatf("fv%0d_stop", i), fr[fv[i].nb - 1], 1);
      chk($sformatf("fv%0d_end_busy", i), busy, 0);
    end

    // back-to-back frames and overrun
    wr(2, 8'h01); wr(3, 8'h00); wr(0, 8'h55); wr(0, 8'hAA);
    chk("b2b_start1", tx, 0);
    wr(0, 8'h33);
    rd(1, "ovr_set", 8'h06);
    wr(1, 8'h01);
    rd(1, "ovr_clr", 8'h02);
    rx_frame(4, 10, 4, fr);
    chk("b2b_d1", fr[8:1], 8'h55);
    chk("b2b_no_gap", tx, 0);
    rx_frame(4, 10, 0, fr);
    chk("b2b_d2", fr[8:1], 8'hAA);
    chk("b2b_stop2", fr[9], 1);
    rd(0, "data_rd", 8'hAA);

    // IRQ with enable gating
    wr(2, 8'h09); @(negedge clk);
    chk("irq_empty", irq_n, 0);
    wr(2, 8'h08); wr(0, 8'h5A); @(negedge clk);
    chk("irq_full", irq_n, 1); chk("irq_noen_tx", tx, 1);
    repeat (3) @(negedge clk);
    chk("irq_noen_tx2", tx, 1);
    wr(2, 8'h09);
    chk("irq_en_pre", tx, 1);
    @(negedge clk);
    chk("irq_en_start", tx, 0);
    @(negedge clk);
    chk("irq_back", irq_n, 0);
    wait_idle(200);

    // divisor change in the middle of data bit 0
    wr(2, 8'h01); wr(3, 8'd3); wr(0, 8'h05);
    @(negedge clk);
    chk("div_start", tx, 0);
    repeat (19) @(negedge clk);
    wr(3, 8'd1);
    repeat (11) @(negedge clk); chk("div_b0_tail", tx, 1);
    @(negedge clk);             chk("div_b1_head", tx, 0);
    repeat (7) @(negedge clk);  chk("div_b1_tail", tx, 0);
    @(negedge clk);             chk("div_b2_head", tx, 1);
    repeat (7) @(negedge clk);  chk("div_b2_tail", tx, 1);
    @(negedge clk);             chk("div_b3_head", tx, 0);
    wait_idle(200);

    // randomized traffic against the model
    for (int r = 0; r < 6; r++) begin
      wr(2, 8'($urandom_range(0, 15)) | 8'h01);
      wr(3, 8'($urandom_range(0, 2)));
      for (int k = 0; k < 150; k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: wr(0, 8'($urandom));
          3:       begin addr = 2'($urandom_range(0, 3)); rd(addr, "rnd_rd", m_rd(addr)); end
          4:       wr(1, 8'($urandom_range(0, 1)));
          5:       wr(2, 8'($urandom_range(0, 15)) | (($urandom_range(0, 4) != 0) ? 8'h01 : 8'h00));
          6:       wr(3, 8'($urandom_range(0, 2)));
          default: idle($urandom_range(1, 6));
        endcase
      end
      wr(2, 8'h01);
      wait_idle(3000);
    end

    // asynchronous reset in the middle of a frame
    wr(3, 8'd0); wr(0, 8'hF0);
    @(negedge clk);
    chk("rstmid_start", tx, 0);
    #2 reset_n = 1'b0;
    #1 chk("rstmid_tx", tx, 1);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    foreach (rv[i]) rd(rv[i].a, $sformatf("rst2_reg%0d", rv[i].a), rv[i].exp);
    chk("rst2_irq_n", irq_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
